// File: rtl/nbc_seq_tracker.sv
// Receive-side tracker for the 7-step 2-bit sequence 0,3,1,2,2,1,3.
// Hunts for the 0 anchor, verifies LOCK_COUNT matches, then flywheels and counts errors while locked.
module nbc_seq_tracker #(
    parameter int LOCK_COUNT = 7,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       in_data,
    input  logic             in_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic [2:0]       phase,
    output logic             err_pulse,
    output logic             period_done,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

    state_t     state_q, state_d;
    logic [2:0] exp_q, exp_d;
    logic [3:0] match_q, match_d;
    logic [3:0] miss_q, miss_d;
    logic [2:0] phase_d;
    logic       err_pulse_d;
    logic       period_done_d;
    logic       err_inc;
    logic [2:0] exp_next;
    logic       sample_ok;

    function automatic logic [1:0] seq_sym(input logic [2:0] idx);
        case (idx)
            3'd0:    seq_sym = 2'd0;
            3'd1:    seq_sym = 2'd3;
            3'd2:    seq_sym = 2'd1;
            3'd3:    seq_sym = 2'd2;
            3'd4:    seq_sym = 2'd2;
            3'd5:    seq_sym = 2'd1;
            3'd6:    seq_sym = 2'd3;
            default: seq_sym = 2'd0;
        endcase
    endfunction

    assign exp_next  = (exp_q == 3'd6) ? 3'd0 : exp_q + 3'd1;
    assign sample_ok = (in_data == seq_sym(exp_q));

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        match_d       = match_q;
        miss_d        = miss_q;
        phase_d       = phase;
        err_pulse_d   = 1'b0;
        period_done_d = 1'b0;
        err_inc       = 1'b0;
        if (in_valid) begin
            case (state_q)
                HUNT: begin
                    phase_d = 3'd0;
                    if (in_data == 2'd0) begin
                        state_d = VERIFY;
                        exp_d   = 3'd1;
                        match_d = 4'd0;
                    end
                end
                VERIFY: begin
                    phase_d = 3'd0;
                    if (sample_ok) begin
                        exp_d   = exp_next;
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == LOCK_C) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                            phase_d = exp_q;
                        end
                    end else if (in_data == 2'd0) begin
                        exp_d   = 3'd1;
                        match_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                        match_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the expected index advances whether or not the sample matched.
                    exp_d         = exp_next;
                    phase_d       = exp_q;
                    period_done_d = (exp_q == 3'd6);
                    if (sample_ok) begin
                        miss_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        miss_d      = miss_q + 4'd1;
                        if (miss_q + 4'd1 == LOSS_C) begin
                            state_d = HUNT;
                            phase_d = 3'd0;
                            miss_d  = 4'd0;
                            match_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    phase_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HUNT;
            exp_q       <= 3'd0;
            match_q     <= 4'd0;
            miss_q      <= 4'd0;
            phase       <= 3'd0;
            err_pulse   <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            phase       <= phase_d;
            err_pulse   <= err_pulse_d;
            period_done <= period_done_d;
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clock) begin
        if (reset || err_clr) begin
            err_count <= '0;
        end else if (err_inc && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule
